// File: rtl/framebuffer_scanout.sv
// rtl/framebuffer_scanout.sv - VGA raster scanout of a SCALE-replicated, double-buffered framebuffer
// Two-stage pipeline: counters -> RAM/flags -> pins; buffer swaps only at the first vblank line.
module framebuffer_scanout #(
  parameter int BUFFER_WIDTH      = 160,
  parameter int BUFFER_HEIGHT     = 120,
  parameter int BUFFER_DATA_WIDTH = 12,
  parameter int BUFFER_ADDR_WIDTH = $clog2(BUFFER_WIDTH * BUFFER_HEIGHT),
  parameter int SCALE             = 4,
  parameter int H_VISIBLE         = 640,
  parameter int H_FRONT           = 16,
  parameter int H_SYNC            = 96,
  parameter int H_BACK            = 48,
  parameter int V_VISIBLE         = 480,
  parameter int V_FRONT           = 10,
  parameter int V_SYNC            = 2,
  parameter int V_BACK            = 33
) (
  input  logic                         clk,
  input  logic                         rstn,
  output logic [BUFFER_ADDR_WIDTH-1:0] read_addr,
  output logic                         read_buf_sel,
  input  logic [BUFFER_DATA_WIDTH-1:0] read_data,
  input  logic                         swap_req,
  output logic                         swap_ack,
  output logic                         active_buffer,
  output logic                         vblank_start,
  output logic                         hsync,
  output logic                         vsync,
  output logic [3:0]                   vga_r,
  output logic [3:0]                   vga_g,
  output logic [3:0]                   vga_b
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int AW      = BUFFER_ADDR_WIDTH;
  localparam int SHIFT   = $clog2(SCALE);

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
  localparam logic [HW-1:0] H_VIS    = HW'(H_VISIBLE);
  localparam logic [HW-1:0] HS_BEGIN = HW'(H_VISIBLE + H_FRONT);
  localparam logic [HW-1:0] HS_END   = HW'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
  localparam logic [VW-1:0] V_VIS    = VW'(V_VISIBLE);
  localparam logic [VW-1:0] VS_BEGIN = VW'(V_VISIBLE + V_FRONT);
  localparam logic [VW-1:0] VS_END   = VW'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [AW-1:0] ROW_PITCH = AW'(BUFFER_WIDTH);

  typedef enum logic {
    S_IDLE,
    S_PENDING
  } swap_state_e;

  logic [HW-1:0] h_cnt_q, h_cnt_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d;
  logic          visible;
  logic          hsync_region;
  logic          vsync_region;
  logic          swap_point;
  logic [AW-1:0] addr_calc;

  logic          vis1_q;
  logic          hs1_q;
  logic          vs1_q;
  logic          hsync_q;
  logic          vsync_q;
  logic [3:0]    r_q, g_q, b_q;

  swap_state_e   state_q;
  logic          active_q;
  logic          ack_q;
  logic          vbs_q;

  always_comb begin
    h_cnt_d = h_cnt_q + HW'(1);
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == H_LAST) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + VW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  assign visible      = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
  assign hsync_region = (h_cnt_q >= HS_BEGIN) && (h_cnt_q < HS_END);
  assign vsync_region = (v_cnt_q >= VS_BEGIN) && (v_cnt_q < VS_END);
  assign swap_point   = (h_cnt_q == '0) && (v_cnt_q == V_VIS);

  // Each stored pixel covers a SCALE x SCALE block; wrap in AW bits is intended.
  assign addr_calc = AW'(h_cnt_q >> SHIFT) + (AW'(v_cnt_q >> SHIFT) * ROW_PITCH);
  assign read_addr = visible ? addr_calc : '0;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      vis1_q  <= 1'b0;
      hs1_q   <= 1'b1;
      vs1_q   <= 1'b1;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
      r_q     <= '0;
      g_q     <= '0;
      b_q     <= '0;
    end else begin
      vis1_q  <= visible;
      hs1_q   <= ~hsync_region;
      vs1_q   <= ~vsync_region;
      hsync_q <= hs1_q;
      vsync_q <= vs1_q;
      if (vis1_q) begin
        r_q <= read_data[11:8];
        g_q <= read_data[7:4];
        b_q <= read_data[3:0];
      end else begin
        r_q <= '0;
        g_q <= '0;
        b_q <= '0;
      end
    end
  end

  // A request coinciding with the swap point is honoured in the same frame.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q  <= S_IDLE;
      active_q <= 1'b0;
      ack_q    <= 1'b0;
      vbs_q    <= 1'b0;
    end else begin
      vbs_q <= swap_point;
      ack_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (swap_req && swap_point) begin
            active_q <= ~active_q;
            ack_q    <= 1'b1;
          end else if (swap_req) begin
            state_q <= S_PENDING;
          end
        end
        S_PENDING: begin
          if (swap_point) begin
            active_q <= ~active_q;
            ack_q    <= 1'b1;
            state_q  <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign read_buf_sel  = active_q;
  assign active_buffer = active_q;
  assign swap_ack      = ack_q;
  assign vblank_start  = vbs_q;
  assign hsync         = hsync_q;
  assign vsync         = vsync_q;
  assign vga_r         = r_q;
  assign vga_g         = g_q;
  assign vga_b         = b_q;

endmodule

// File: tb/tb_framebuffer_scanout.sv
// tb/tb_framebuffer_scanout.sv - bench for framebuffer_scanout on a reduced raster geometry
// Raster shrunk to 64x48 visible (80x55 total) so several frames fit in a short run.
module tb_framebuffer_scanout;

  localparam int BW = 16;
  localparam int BH = 12;
  localparam int SC = 4;
  localparam int HV = 64;
  localparam int HF = 4;
  localparam int HS = 8;
  localparam int HB = 4;
  localparam int VV = 48;
  localparam int VF = 2;
  localparam int VS = 2;
  localparam int VB = 3;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;
  localparam int FR = HT * VT;
  localparam int SPP = VV * HT;
  localparam int AW = $clog2(BW * BH);

  logic          clk;
  logic          rstn;
  logic [AW-1:0] read_addr;
  logic          read_buf_sel;
  logic [11:0]   read_data;
  logic          swap_req;
  logic          swap_ack;
  logic          active_buffer;
  logic          vblank_start;
  logic          hsync;
  logic          vsync;
  logic [3:0]    vga_r, vga_g, vga_b;

  framebuffer_scanout #(
    .BUFFER_WIDTH(BW), .BUFFER_HEIGHT(BH), .BUFFER_DATA_WIDTH(12),
    .BUFFER_ADDR_WIDTH(AW), .SCALE(SC),
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
  ) dut (
    .clk(clk), .rstn(rstn), .read_addr(read_addr), .read_buf_sel(read_buf_sel),
    .read_data(read_data), .swap_req(swap_req), .swap_ack(swap_ack),
    .active_buffer(active_buffer), .vblank_start(vblank_start),
    .hsync(hsync), .vsync(vsync), .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous dual-buffer RAM: buffer 1 holds the complement of buffer 0.
  always @(posedge clk)
    read_data <= read_buf_sel ? ~12'(read_addr) : 12'(read_addr);

  int errors = 0;
  int checks = 0;
  logic chk_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic int addr_of(input int pos);
    int h, v;
    h = pos % HT;
    v = pos / HT;
    if (h < HV && v < VV) return (h / SC) + (v / SC) * BW;
    return 0;
  endfunction

  // {hsync, vsync, r, g, b} produced by raster position pos scanned from buffer b
  function automatic logic [13:0] pix_of(input int pos, input logic b);
    int h, v;
    logic [11:0] d;
    logic hs, vs;
    h = pos % HT;
    v = pos / HT;
    d = 12'(addr_of(pos));
    if (b) d = ~d;
    if (!(h < HV && v < VV)) d = 12'h000;
    hs = !(h >= HV + HF && h < HV + HF + HS);
    vs = !(v >= VV + VF && v < VV + VF + VS);
    return {hs, vs, d};
  endfunction

  int          m_pos;
  logic        m_pend, m_buf;
  int          p1_pos;
  logic        p1_buf, p1_ok;
  logic        e_ack, e_vbs;
  logic [13:0] e_pix;
  int          pb;
  logic        bb, r_s, q_s, sp;

  always @(posedge clk) begin
    r_s = rstn;
    q_s = swap_req;
    if (!r_s) begin
      m_pos = 0; m_pend = 1'b0; m_buf = 1'b0; p1_ok = 1'b0;
      e_ack = 1'b0; e_vbs = 1'b0; e_pix = 14'h3000;
    end else begin
      pb = m_pos;
      bb = m_buf;
      sp = (m_pos == SPP);
      e_vbs = sp;
      e_ack = sp && (m_pend || q_s);
      if (e_ack) begin
        m_buf = ~m_buf;
        m_pend = 1'b0;
      end else if (q_s) begin
        m_pend = 1'b1;
      end
      e_pix = p1_ok ? pix_of(p1_pos, p1_buf) : 14'h3000;
      p1_pos = pb;
      p1_buf = bb;
      p1_ok = 1'b1;
      m_pos = (m_pos + 1) % FR;
    end
    #1;
    if (chk_on) begin
      chk("active_buffer", 32'(active_buffer), 32'(m_buf));
      chk("read_buf_sel", 32'(read_buf_sel), 32'(m_buf));
      chk("swap_ack", 32'(swap_ack), 32'(e_ack));
      chk("vblank_start", 32'(vblank_start), 32'(e_vbs));
      chk("pins", 32'({hsync, vsync, vga_r, vga_g, vga_b}), 32'(e_pix));
      chk("read_addr", 32'(read_addr), 32'(addr_of(m_pos)));
    end
  end

  int cur, hs_lo, vs_lo, acks, vbs_cur, vbs_prev;

  task automatic tick();
    @(negedge clk);
    cur++;
    if (!hsync) hs_lo++;
    if (!vsync) vs_lo++;
    if (swap_ack) acks++;
    if (vblank_start) begin
      vbs_prev = vbs_cur;
      vbs_cur = cur;
    end
  endtask

  task automatic goto(input int t);
    while (cur < t) tick();
  endtask

  task automatic pulse_req();
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
  endtask

  initial begin
    rstn = 1'b0;
    swap_req = 1'b0;
    cur = 0; hs_lo = 0; vs_lo = 0; acks = 0; vbs_cur = 0; vbs_prev = 0;
    repeat (3) @(negedge clk);
    chk_on = 1'b1;
    @(negedge clk);
    rstn = 1'b1;
    cur = 0;

    // Frame 0: pixel replication, sync placement, frame length
    chk("lit_reset_active", 32'(active_buffer), 32'd0);
    goto(2);
    chk("lit_first_px", 32'({vga_r, vga_g, vga_b}), 32'h000);
    hs_lo = 0; vs_lo = 0;
    goto(6);   chk("lit_col4", 32'({vga_r, vga_g, vga_b}), 32'h001);
    goto(69);  chk("lit_hs_before", 32'(hsync), 32'd1);
    goto(70);  chk("lit_hs_start", 32'(hsync), 32'd0);
    goto(77);  chk("lit_hs_last", 32'(hsync), 32'd0);
    goto(78);  chk("lit_hs_end", 32'(hsync), 32'd1);
    goto(84);  chk("lit_row1_col2", 32'({vga_r, vga_g, vga_b}), 32'h000);
    goto(88);  chk("lit_row1_col6", 32'({vga_r, vga_g, vga_b}), 32'h001);
    goto(322); chk("lit_row4", 32'({vga_r, vga_g, vga_b}), 32'h010);
    goto(3841);
    chk("lit_vbs_first", 32'(vblank_start), 32'd1);
    chk("lit_no_ack", 32'(swap_ack), 32'd0);
    goto(4001); chk("lit_vs_before", 32'(vsync), 32'd1);
    goto(4002); chk("lit_vs_start", 32'(vsync), 32'd0);
    goto(4402);
    chk("lit_hs_count", 32'(hs_lo), 32'd440);
    chk("lit_vs_count", 32'(vs_lo), 32'd160);

    // Frame 1: request mid-frame, swap at the swap point
    goto(4400 + 20 * HT + 5);
    pulse_req();
    goto(8240);
    chk("lit_pre_swap_buf", 32'(active_buffer), 32'd0);
    goto(8241);
    chk("lit_swap_ack", 32'(swap_ack), 32'd1);
    chk("lit_swap_vbs", 32'(vblank_start), 32'd1);
    chk("lit_swap_buf", 32'(active_buffer), 32'd1);
    chk("lit_frame_len", 32'(vbs_cur - vbs_prev), 32'd4400);
    goto(8242);
    chk("lit_ack_one_cycle", 32'(swap_ack), 32'd0);

    // Frame 2: three requests merge into one swap
    acks = 0;
    goto(8800 + 5 * HT);  pulse_req();
    goto(8800 + 10 * HT); pulse_req();
    goto(8800 + 30 * HT); pulse_req();
    goto(13242);
    chk("lit_merged_acks", 32'(acks), 32'd1);
    chk("lit_merged_buf", 32'(active_buffer), 32'd0);

    // Frame 3: request on the swap-point cycle swaps in the same frame
    goto(13200 + SPP);
    pulse_req();
    chk("lit_same_cycle_ack", 32'(swap_ack), 32'd1);
    chk("lit_same_cycle_buf", 32'(active_buffer), 32'd1);

    // Frame 4: request one cycle late waits a whole frame
    goto(17600 + SPP + 1);
    chk("lit_late_no_ack", 32'(swap_ack), 32'd0);
    pulse_req();
    goto(17600 + SPP + 2);
    chk("lit_late_buf_hold", 32'(active_buffer), 32'd1);
    goto(22000 + SPP + 1);
    chk("lit_late_ack", 32'(swap_ack), 32'd1);
    chk("lit_late_buf", 32'(active_buffer), 32'd0);

    // Frame 6: reset mid-frame with a swap pending
    goto(26400 + 10 * HT);
    pulse_req();
    goto(26400 + 30 * HT);
    rstn = 1'b0;
    repeat (3) tick();
    rstn = 1'b1;
    cur = 0; acks = 0;
    chk("lit_rst_hsync", 32'(hsync), 32'd1);
    chk("lit_rst_vsync", 32'(vsync), 32'd1);
    chk("lit_rst_buf", 32'(active_buffer), 32'd0);
    goto(6);
    chk("lit_rst_col4", 32'({vga_r, vga_g, vga_b}), 32'h001);
    goto(4402);
    chk("lit_rst_no_ack", 32'(acks), 32'd0);
    chk("lit_rst_buf_end", 32'(active_buffer), 32'd0);

    chk_on = 1'b0;
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
